// File: rtl/vga_cap_pkg.sv
// Shared types and constants for the VGA capture receiver.
// Holds the capture FSM encoding, datapath widths and timing-lock thresholds.
package vga_cap_pkg;

  localparam int unsigned RGB_W       = 12;
  localparam int unsigned CNT_W       = 12;
  localparam int unsigned LOCK_LINES  = 4;
  localparam int unsigned LOCK_FRAMES = 2;
  localparam int unsigned MATCH_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/vga_cap_fifo.sv
// 4-deep valid/ready FIFO; a push while full is accepted only if the head pops in the same cycle.
// The head reads as zero while empty so the outputs stay clean after reset.
module vga_cap_fifo #(
  parameter int unsigned DATA_W = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned DEPTH = 4;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  logic              pop;
  logic              wr_en;

  assign valid = (count != '0);
  assign full  = (count == 3'(DEPTH));
  assign pop   = valid & ready;
  assign wr_en = push & (~full | pop);
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b00, wr_en} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_capture_rx.sv
// VGA loopback receiver: measures line/sync/frame timing and captures one frame window on request
// as an {addr, rgb} stream through a small FIFO.
module vga_capture_rx
  import vga_cap_pkg::*;
#(
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned HSTART   = 144,
  parameter int unsigned HACTIVE  = 640,
  parameter int unsigned VSTART   = 35,
  parameter int unsigned VACTIVE  = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              pix_ce,
  input  logic              vga_h,
  input  logic              vga_v,
  input  logic [3:0]        vga_r,
  input  logic [3:0]        vga_g,
  input  logic [3:0]        vga_b,
  input  logic              arm,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [RGB_W-1:0]  pix_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              short_frame,
  output logic              locked,
  output logic [CNT_W-1:0]  meas_htotal,
  output logic [CNT_W-1:0]  meas_hsync,
  output logic [CNT_W-1:0]  meas_vtotal
);

  localparam logic [CNT_W-1:0]   H_LO      = CNT_W'(HSTART);
  localparam logic [CNT_W-1:0]   H_HI      = CNT_W'(HSTART + HACTIVE - 1);
  localparam logic [CNT_W-1:0]   V_LO      = CNT_W'(VSTART);
  localparam logic [CNT_W-1:0]   V_HI      = CNT_W'(VSTART + VACTIVE - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(HACTIVE * VACTIVE - 1);
  localparam logic [MATCH_W-1:0] H_LOCK    = MATCH_W'(LOCK_LINES - 1);
  localparam logic [MATCH_W-1:0] V_LOCK    = MATCH_W'(LOCK_FRAMES - 1);

  cap_state_t          state;
  logic                s_ce, h_s, h_p, v_s, v_p;
  logic [RGB_W-1:0]    rgb_s;
  logic [CNT_W-1:0]    hcnt, vcnt, hs_w, h_idx, v_idx, htot_new, vtot_new;
  logic [MATCH_W-1:0]  h_match, v_match, h_match_nxt, v_match_nxt;
  logic                h_lead, h_trail, v_lead, in_win;
  logic [ADDR_W-1:0]   addr, push_addr;
  logic                push, last, pop, fifo_full;
  logic [ADDR_W+RGB_W-1:0] fifo_head;

  // Sync bits are stored as "active" so the edge logic is polarity-independent;
  // s_ce marks the cycle a fresh sample sits in the register.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      s_ce  <= 1'b0;
      h_s   <= 1'b0;
      h_p   <= 1'b0;
      v_s   <= 1'b0;
      v_p   <= 1'b0;
      rgb_s <= '0;
    end else begin
      s_ce <= pix_ce;
      if (pix_ce) begin
        h_s   <= (vga_h == SYNC_POL);
        h_p   <= h_s;
        v_s   <= (vga_v == SYNC_POL);
        v_p   <= v_s;
        rgb_s <= {vga_r, vga_g, vga_b};
      end
    end
  end

  assign h_lead   = s_ce & h_s & ~h_p;
  assign h_trail  = s_ce & ~h_s & h_p;
  assign v_lead   = s_ce & v_s & ~v_p;
  assign h_idx    = h_lead ? '0 : ((&hcnt) ? hcnt : hcnt + 1'b1);
  assign v_idx    = v_lead ? '0 : (h_lead ? ((&vcnt) ? vcnt : vcnt + 1'b1) : vcnt);
  assign htot_new = hcnt + 1'b1;
  assign vtot_new = vcnt + 1'b1;
  assign in_win   = s_ce && (h_idx >= H_LO) && (h_idx <= H_HI) && (v_idx >= V_LO) && (v_idx <= V_HI);

  always_comb begin
    h_match_nxt = h_match;
    v_match_nxt = v_match;
    if (h_lead) h_match_nxt = (htot_new != meas_htotal) ? '0 : ((h_match == H_LOCK) ? h_match : h_match + 1'b1);
    if (v_lead) v_match_nxt = (vtot_new != meas_vtotal) ? '0 : ((v_match == V_LOCK) ? v_match : v_match + 1'b1);
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hs_w        <= '0;
      h_match     <= '0;
      v_match     <= '0;
      meas_htotal <= '0;
      meas_hsync  <= '0;
      meas_vtotal <= '0;
      locked      <= 1'b0;
    end else begin
      h_match <= h_match_nxt;
      v_match <= v_match_nxt;
      locked  <= (h_match_nxt >= H_LOCK) && (v_match_nxt >= V_LOCK);
      if (s_ce) begin
        hcnt <= h_idx;
        vcnt <= v_idx;
        if (h_s)     hs_w <= h_lead ? CNT_W'(1) : ((&hs_w) ? hs_w : hs_w + 1'b1);
        if (h_trail) meas_hsync  <= hs_w;
        if (h_lead)  meas_htotal <= htot_new;
        if (v_lead)  meas_vtotal <= vtot_new;
      end
    end
  end

  // The VSYNC edge that starts a capture may itself carry the first window pixel (address 0).
  assign push_addr = (state == ST_ARMED) ? '0 : addr;
  assign push      = in_win && (((state == ST_CAPTURE) && !v_lead) || ((state == ST_ARMED) && v_lead));
  assign last      = (push_addr == LAST_ADDR);
  assign pop       = pix_valid & pix_ready;
  assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE) || (state == ST_DRAIN);

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (push) addr <= push_addr + 1'b1;
      unique case (state)
        ST_IDLE, ST_DONE: if (arm) begin
          overflow    <= 1'b0;
          short_frame <= 1'b0;
          done        <= 1'b0;
          state       <= ST_ARMED;
        end
        ST_ARMED: if (v_lead) begin
          if (!push) addr <= '0;
          state <= (push && last) ? ST_DRAIN : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (v_lead) begin
            short_frame <= 1'b1;
            state       <= ST_DRAIN;
          end else if (push && last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (!pix_valid) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  vga_cap_fifo #(
    .DATA_W(ADDR_W + RGB_W)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_reset),
    .push     (push),
    .push_data({push_addr, rgb_s}),
    .full     (fifo_full),
    .valid    (pix_valid),
    .ready    (pix_ready),
    .data     (fifo_head)
  );

  assign pix_addr = fifo_head[ADDR_W+RGB_W-1:RGB_W];
  assign pix_data = fifo_head[RGB_W-1:0];

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed + randomized bench for vga_capture_rx: a counter-driven VGA source feeds the DUT and the
// captured stream is compared against the frame window computed from source coordinates.
module tb_vga_capture_rx;

  localparam int unsigned HSTART  = 4;
  localparam int unsigned HACTIVE = 8;
  localparam int unsigned VSTART  = 2;
  localparam int unsigned VACTIVE = 4;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned HT      = 20;
  localparam int unsigned HSW     = 3;
  localparam int unsigned VSW     = 2;

  logic              sys_clk = 1'b0;
  logic              sys_reset, pix_ce, vga_h, vga_v, arm, pix_valid, pix_ready;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic [ADDR_W-1:0] pix_addr;
  logic [11:0]       pix_data;
  logic              busy, done, overflow, short_frame, locked;
  logic [11:0]       meas_htotal, meas_hsync, meas_vtotal;

  int          total = 0;
  int          bad   = 0;
  int          src_h, src_v;
  int          src_vt    = 10;
  bit          ce_toggle = 1'b0;
  bit          rnd_img   = 1'b0;
  logic [11:0] img [10][20];
  logic [30:0] got_q [$];

  vga_capture_rx #(
    .SYNC_POL(1'b0),
    .HSTART  (HSTART),
    .HACTIVE (HACTIVE),
    .VSTART  (VSTART),
    .VACTIVE (VACTIVE),
    .ADDR_W  (ADDR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .pix_ce     (pix_ce),
    .vga_h      (vga_h),
    .vga_v      (vga_v),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .arm        (arm),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .short_frame(short_frame),
    .locked     (locked),
    .meas_htotal(meas_htotal),
    .meas_hsync (meas_hsync),
    .meas_vtotal(meas_vtotal)
  );

  always #5 sys_clk = ~sys_clk;

  // Video source: line/frame counters advance once per enabled pixel; syncs active-low at count start.
  initial begin
    logic [11:0] px;
    src_h  = 0;
    src_v  = 0;
    pix_ce = 1'b1;
    forever begin
      vga_h = (src_h < int'(HSW)) ? 1'b0 : 1'b1;
      vga_v = (src_v < int'(VSW)) ? 1'b0 : 1'b1;
      px    = rnd_img ? img[src_v][src_h] : {4'(src_v), 4'(src_h), 4'h5};
      {vga_r, vga_g, vga_b} = px;
      @(negedge sys_clk);
      if (pix_ce) begin
        src_h++;
        if (src_h == int'(HT)) begin
          src_h = 0;
          src_v++;
          if (src_v >= src_vt) src_v = 0;
        end
      end
      pix_ce = ce_toggle ? ~pix_ce : 1'b1;
    end
  end

  // Records every accepted transfer; sampled mid-cycle, the transfer completes at the next rising edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      #1;
      if (sys_reset === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1)
        got_q.push_back({pix_addr, pix_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] exp_pix(input int i, input bit use_img);
    int          y, x;
    logic [11:0] d;
    y = i / int'(HACTIVE);
    x = i % int'(HACTIVE);
    d = use_img ? img[int'(VSTART) + y][int'(HSTART) + x] : {4'(int'(VSTART) + y), 4'(int'(HSTART) + x), 4'h5};
    return {19'(i), d};
  endfunction

  task automatic check_stream(input string tag, input int n, input bit use_img);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_pix(i, use_img));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_addr"}, pix_addr, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_short"}, short_frame, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_htot"}, meas_htotal, 0);
    chk({tag, "_hsync"}, meas_hsync, 0);
    chk({tag, "_vtot"}, meas_vtotal, 0);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge sys_clk);
    arm = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int c = 0; c < limit && done !== 1'b1; c++) @(negedge sys_clk);
    chk(tag, done, 1);
  endtask

  task automatic wait_got(input int n, input int limit);
    for (int c = 0; c < limit && got_q.size() < n; c++) @(negedge sys_clk);
  endtask

  initial begin
    int stall;
    sys_reset = 1'b0;
    arm       = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset("rst");
    sys_reset = 1'b1;

    // Timing measurement over several frames, no capture requested.
    repeat (650) @(negedge sys_clk);
    chk("meas_htotal", meas_htotal, HT);
    chk("meas_hsync", meas_hsync, HSW);
    chk("meas_vtotal", meas_vtotal, 10);
    chk("locked", locked, 1);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    // Full capture with an always-ready consumer.
    got_q.delete();
    do_arm();
    wait_done("cap_done", 600);
    check_stream("cap", 32, 1'b0);
    chk("cap_addr9_data", (got_q.size() > 9) ? got_q[9] : '0, {19'd9, 12'h355});
    chk("cap_ovf", overflow, 0);
    chk("cap_short", short_frame, 0);
    chk("cap_busy", busy, 0);

    // Consumer stalled for the whole capture: only the first four pixels survive.
    pix_ready = 1'b0;
    got_q.delete();
    do_arm();
    repeat (450) @(negedge sys_clk);
    chk("bp_busy", busy, 1);
    chk("bp_done", done, 0);
    chk("bp_ovf", overflow, 1);
    chk("bp_valid", pix_valid, 1);
    chk("bp_held", got_q.size(), 0);
    pix_ready = 1'b1;
    wait_done("bp_done_after", 50);
    check_stream("bp", 4, 1'b0);
    chk("bp_ovf_kept", overflow, 1);

    // Random image with sparse random consumer stalls (one per 10 cycles keeps the FIFO from filling).
    for (int v = 0; v < 10; v++)
      for (int h = 0; h < 20; h++)
        img[v][h] = 12'($urandom);
    rnd_img = 1'b1;
    got_q.delete();
    do_arm();
    stall = 0;
    for (int c = 0; c < 1200 && done !== 1'b1; c++) begin
      if (c % 10 == 0) stall = $urandom_range(0, 9);
      pix_ready = ((c % 10) != stall);
      @(negedge sys_clk);
    end
    pix_ready = 1'b1;
    chk("rnd_done", done, 1);
    check_stream("rnd", 32, 1'b1);
    chk("rnd_ovf", overflow, 0);
    rnd_img = 1'b0;

    // Frame shortened to 4 lines while line VSTART+1 is being captured.
    got_q.delete();
    do_arm();
    wait_got(10, 600);
    src_vt = 4;
    wait_done("sf_done", 400);
    chk("sf_short", short_frame, 1);
    chk("sf_locked", locked, 0);
    chk("sf_vtot", meas_vtotal, 4);
    check_stream("sf", 16, 1'b0);
    src_vt = 10;

    // Asynchronous reset once address 15 has been delivered, then a clean recapture.
    got_q.delete();
    do_arm();
    wait_got(16, 600);
    chk("ar_reached15", got_q.size(), 16);
    sys_reset = 1'b0;
    #1;
    check_reset("arst");
    repeat (2) @(negedge sys_clk);
    sys_reset = 1'b1;
    @(negedge sys_clk);
    got_q.delete();
    do_arm();
    wait_done("rc_done", 800);
    check_stream("rc", 32, 1'b0);

    // Pixel enable at half rate; sync edges coincide at every frame start.
    ce_toggle = 1'b1;
    repeat (2) @(negedge sys_clk);
    got_q.delete();
    do_arm();
    wait_done("ce_done", 2500);
    check_stream("ce", 32, 1'b0);
    chk("ce_htot", meas_htotal, HT);
    chk("ce_hsync", meas_hsync, HSW);
    chk("ce_vtot", meas_vtotal, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_capture_rx.md
Name: vga_capture_rx

Overview:
- Receiver end of the board VGA output: samples the 12-bit RGB/HSYNC/VSYNC stream at the pixel rate.
- Measures incoming timing: line length, sync width and frame height.
- On request, captures one frame window as a linear pixel stream through a 4-entry buffer, for a frame-store or checker.
- Used in loopback to verify the video controller in hardware and in sim without VPI.

Parameters:
- SYNC_POL, 0: sync active level (0 = active-low).
- HSTART, 144: pixel-enable (ce) cycles from HSYNC leading edge to first captured pixel.
- HACTIVE, 640: captured pixels per line.
- VSTART, 35: line index of the first captured line, where line 0 = line in progress at the VSYNC leading edge.
- VACTIVE, 480: captured lines.
- ADDR_W, 19: pixel address width.

Ports:
- sys_clk  in  1  pixel-domain clock.
- sys_reset  in  1  async active-low reset.
- pix_ce  in  1  pixel-rate enable; all sampling and counting advances only when this is 1.
- vga_h  in  1  horizontal sync.
- vga_v  in  1  vertical sync.
- vga_r  in  4  red.
- vga_g  in  4  green.
- vga_b  in  4  blue.
- arm  in  1  one-cycle request to capture the next frame.
- pix_valid  out  1  output pixel available.
- pix_ready  in  1  consumer accepts the pixel.
- pix_addr  out  ADDR_W  linear address, y*HACTIVE+x.
- pix_data  out  12  pixel as {r,g,b}.
- busy  out  1  state is ARMED, CAPTURE or DRAIN.
- done  out  1  frame capture complete.
- overflow  out  1  sticky: a pixel was dropped because the buffer was full.
- short_frame  out  1  sticky: VSYNC arrived before VACTIVE lines were captured.
- locked  out  1  timing is stable.
- meas_htotal  out  12  ce cycles per line.
- meas_hsync  out  12  ce cycles of HSYNC active.
- meas_vtotal  out  12  lines per frame.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, all counters 0.
- Input sampling: inputs are registered on each ce cycle. Edge detection uses the registered value against its previous value, normalised by SYNC_POL.
- Horizontal counter (hcnt, 12 bit): set to 0 on the ce cycle where the HSYNC leading edge is detected, otherwise increments; saturates at 4095.
- On each HSYNC leading edge: meas_htotal <= hcnt+1.
- HSYNC width (hs_w): counts ce cycles while HSYNC is active. On the trailing edge, meas_hsync <= hs_w.
- Vertical counter (vcnt, 12 bit): cleared on the VSYNC leading edge; otherwise incremented on the HSYNC leading edge. If both edges occur on the same cycle, vcnt = 0.
- On each VSYNC leading edge: meas_vtotal <= vcnt+1.
- locked = 1 when meas_htotal is unchanged over 4 consecutive lines AND meas_vtotal is unchanged over 2 consecutive frames. Any mismatch clears locked on the cycle the new measurement lands.
- In-window pixel: hcnt in [HSTART, HSTART+HACTIVE-1] and vcnt in [VSTART, VSTART+VACTIVE-1].
- FSM states: IDLE, ARMED, CAPTURE, DRAIN, DONE.
  - IDLE --arm--> ARMED. The same transition clears overflow, short_frame and done.
  - ARMED --VSYNC leading edge--> CAPTURE. The address counter is cleared.
  - CAPTURE: each in-window pixel is pushed as {addr, rgb}, then addr increments. After the last window pixel (addr == HACTIVE*VACTIVE-1 pushed or dropped), go to DRAIN.
  - CAPTURE, VSYNC leading edge before the window completes: set short_frame, go to DRAIN.
  - DRAIN --buffer empty--> DONE.
  - DONE: done = 1; arm --> ARMED, which clears done and the sticky flags.
  - arm is ignored in ARMED, CAPTURE and DRAIN.
- Buffer: 4-entry FIFO with valid/ready output. An entry transfers when pix_valid && pix_ready.
  - pix_valid is high iff the FIFO is non-empty; data and address come from the head.
  - Push and pop in the same cycle when full is legal (no drop).
  - Push when full and no pop: pixel dropped, overflow = 1, addr still increments.
- Latency: a pixel appears on pix_valid 2 sys_clk cycles after the ce cycle where it is present on the inputs (sample register + FIFO write).
- Async reset mid-capture: returns to IDLE; the buffer is flushed without output.

Decomposition:
- Shared package vga_cap_pkg: FSM state encoding, RGB width (12), counter width (12), lock thresholds (4 lines, 2 frames).
- One sub-module: vga_cap_fifo, a 4-deep valid/ready FIFO exposing a full flag.

Test Plan:
Bench parameters: HSTART=4, HACTIVE=8, VSTART=2, VACTIVE=4, SYNC_POL=0. Source: htotal 20, hsync 3, vtotal 10, vsync 2 lines, pix_ce=1.

1. Timing measurement: run 3 frames with no arm -> meas_htotal=20, meas_hsync=3, meas_vtotal=10; locked=1 by the end of frame 2; done=0.
2. Full capture: pix_ready=1, rgb = {vcnt[3:0], hcnt[3:0], 4'h5}, arm -> 32 pixels, addr 0..31 in order. Pixel at addr 9 has data = {4'h3, 4'h5, 4'h5}. done=1; overflow=0; short_frame=0.
3. Backpressure: pix_ready=0 throughout the capture -> 4 pixels are held (addr 0..3); overflow=1; FSM stays in DRAIN. Then raise pix_ready -> addr 0..3 drain, then done=1.
4. Short frame: shorten vtotal to 4 lines mid-capture -> short_frame=1; locked falls to 0; done=1 after the drain.
5. Reset mid-capture: deassert sys_reset at addr 15 -> all outputs 0 asynchronously, state IDLE. Then arm -> a fresh capture starts at addr 0.
6. Edge collision: HSYNC and VSYNC leading edges on the same ce cycle -> vcnt=0, meas_vtotal=10. A toggling pix_ce (1 of every 2 cycles) yields identical addresses and data.
